// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: LSB loads/stores and 4-byte fetches over a byte-wide RAM/IO bus.
// Optional: define MEMCTRL_IO_STALL_EN to hold IO-region store bytes while io_buffer_full is high.
module mem_ctrl #(
   parameter int         ADDR_W = 32,
   parameter logic [1:0] IO_HI  = 2'b11
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              rdy_in,
   input  logic              clear,
   input  logic              ls_enable,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       store_val,
   input  logic [3:0]        lsb_type,
   output logic              ls_finished,
   output logic [31:0]       load_val,
   input  logic              if_enable,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_finished,
   output logic [31:0]       if_data,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr,
   input  logic              io_buffer_full
);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_FETCH} state_t;

   state_t            r_state;
   logic [ADDR_W-1:0] r_addr;
   logic [2:0]        r_cnt;
   logic [2:0]        r_n;
   logic [1:0]        r_sz;
   logic              r_uns;
   logic              r_clr;
   logic [31:0]       r_wdata;
   logic [31:0]       r_rdata;

   logic [2:0]        w_n_ls;
   logic [1:0]        w_idx;
   logic [31:0]       w_word;
   logic [31:0]       w_ext;
   logic [ADDR_W-1:0] w_st_a;
   logic              w_stall_acc;
   logic              w_stall_st;

   assign w_n_ls = (lsb_type[1:0] == 2'd0) ? 3'd1 :
                   (lsb_type[1:0] == 2'd1) ? 3'd2 : 3'd4;
   // Read byte k lands two edges after its address, so the byte arriving now is r_cnt-1.
   assign w_idx  = r_cnt[1:0] - 2'd1;
   assign w_st_a = r_addr + ADDR_W'(r_cnt);

`ifdef MEMCTRL_IO_STALL_EN
   assign w_stall_acc = io_buffer_full && (addr[17:16] == IO_HI);
   assign w_stall_st  = io_buffer_full && (w_st_a[17:16] == IO_HI);
`else
   logic w_unused_io;
   assign w_unused_io = io_buffer_full;
   assign w_stall_acc = 1'b0;
   assign w_stall_st  = 1'b0;
`endif

   always_comb begin
      w_word = r_rdata;
      w_word[{w_idx, 3'b000} +: 8] = mem_din;
      case (r_sz)
         2'd0:    w_ext = r_uns ? {24'd0, w_word[7:0]}  : {{24{w_word[7]}},  w_word[7:0]};
         2'd1:    w_ext = r_uns ? {16'd0, w_word[15:0]} : {{16{w_word[15]}}, w_word[15:0]};
         default: w_ext = w_word;
      endcase
   end

   // NOTE: sequential state uses <= only, so every branch below sees pre-edge register values.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_cnt       <= '0;
         r_n         <= '0;
         r_sz        <= '0;
         r_uns       <= 1'b0;
         r_clr       <= 1'b0;
         r_wdata     <= '0;
         r_rdata     <= '0;
         mem_a       <= '0;
         mem_dout    <= '0;
         mem_wr      <= 1'b0;
         ls_finished <= 1'b0;
         if_finished <= 1'b0;
         load_val    <= '0;
         if_data     <= '0;
      end else if (rdy_in) begin
         ls_finished <= 1'b0;
         if_finished <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_cnt <= '0;
               r_clr <= 1'b0;
               if (!clear && ls_enable) begin
                  r_addr  <= addr;
                  r_n     <= w_n_ls;
                  r_sz    <= lsb_type[1:0];
                  r_uns   <= lsb_type[2];
                  r_wdata <= store_val;
                  mem_a   <= addr;
                  if (lsb_type[3]) begin
                     r_state <= S_STORE;
                     if (!w_stall_acc) begin
                        mem_wr   <= 1'b1;
                        mem_dout <= store_val[7:0];
                        r_cnt    <= 3'd1;
                     end
                  end else begin
                     r_state <= S_LOAD;
                  end
               end else if (!clear && if_enable) begin
                  r_addr  <= if_addr;
                  r_n     <= 3'd4;
                  mem_a   <= if_addr;
                  r_state <= S_FETCH;
               end
            end
            S_LOAD, S_FETCH: begin
               if (clear) begin
                  r_state <= S_IDLE;
               end else if (r_cnt == r_n) begin
                  if (r_state == S_LOAD) begin
                     load_val    <= w_ext;
                     ls_finished <= 1'b1;
                  end else begin
                     if_data     <= w_word;
                     if_finished <= 1'b1;
                  end
                  r_state <= S_IDLE;
               end else begin
                  if (r_cnt + 3'd1 < r_n) mem_a <= mem_a + ADDR_W'(1);
                  if (r_cnt != 3'd0) r_rdata[{w_idx, 3'b000} +: 8] <= mem_din;
                  r_cnt <= r_cnt + 3'd1;
               end
            end
            S_STORE: begin
               // A committed store always completes; a flush only hides its pulse.
               if (clear) r_clr <= 1'b1;
               if (r_cnt < r_n) begin
                  if (w_stall_st) begin
                     mem_wr <= 1'b0;
                  end else begin
                     mem_a    <= w_st_a;
                     mem_dout <= r_wdata[{r_cnt[1:0], 3'b000} +: 8];
                     mem_wr   <= 1'b1;
                     r_cnt    <= r_cnt + 3'd1;
                  end
               end else begin
                  mem_wr      <= 1'b0;
                  load_val    <= '0;
                  ls_finished <= !(r_clr || clear);
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
